// File: rtl/xgriscv_muldiv.sv
// xgriscv_muldiv: iterative RV32M/RV64M multiply/divide unit beside the ALU.
// One operation at a time; shift-add multiply and restoring divide, one bit
// per cycle. Divide-by-zero and signed overflow finish at accept.
//
// Handshake: ready is high only in IDLE; an operation is accepted on a rising
// edge where ready=1, start=1 and kill=0. done is a one-cycle pulse during which
// result/tag_out carry the new value; busy covers the CALC phase. kill at any
// edge returns to IDLE without touching result/tag_out.
module xgriscv_muldiv #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [TAGW-1:0] tag_in,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] tag_out,
  output logic [1:0]      dbgState
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      opReg;
  logic [XLEN-1:0] hi, lo, mcand;
  logic            neg;
  logic [TAGW-1:0] tagReg;

  // Accept-time operand preparation and early-out detection
  logic            aNeg, bNeg, signNext, divZero, divOvf, early;
  logic [XLEN-1:0] aMag, bMag, earlyRes;
  always_comb begin
    aNeg     = a[XLEN-1] & ((op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6));
    bNeg     = b[XLEN-1] & ((op == 3'd1) | (op == 3'd4) | (op == 3'd6));
    aMag     = aNeg ? -a : a;
    bMag     = bNeg ? -b : b;
    // Remainder takes the dividend's sign; products and quotients the XOR
    signNext = (op == 3'd6) ? aNeg : (aNeg ^ bNeg);
    divZero  = op[2] & (b == '0);
    divOvf   = op[2] & ~op[0] & (a == MINV) & (b == '1);
    early    = divZero | divOvf;
    if (divZero) earlyRes = op[1] ? a : '1;
    else         earlyRes = op[1] ? '0 : a;
  end

  // One iteration of shift-add multiply or restoring divide, plus final fixup
  logic [XLEN:0]     mulSum, divShift;
  logic              divGe;
  logic [XLEN-1:0]   stepHi, stepLo, divVal;
  logic [2*XLEN-1:0] full, fullRes;
  logic [XLEN-1:0]   finalRes;
  always_comb begin
    mulSum   = {1'b0, hi} + {1'b0, (lo[0] ? mcand : '0)};
    divShift = {hi, lo[XLEN-1]};
    divGe    = divShift >= {1'b0, mcand};
    if (!opReg[2]) begin
      stepHi = mulSum[XLEN:1];
      stepLo = {mulSum[0], lo[XLEN-1:1]};
    end else begin
      stepHi = divGe ? (divShift[XLEN-1:0] - mcand) : divShift[XLEN-1:0];
      stepLo = {lo[XLEN-2:0], divGe};
    end
    full     = {stepHi, stepLo};
    fullRes  = neg ? -full : full;
    divVal   = opReg[1] ? stepHi : stepLo;
    if (!opReg[2]) finalRes = (opReg[1:0] == 2'd0) ? fullRes[XLEN-1:0] : fullRes[2*XLEN-1:XLEN];
    else           finalRes = neg ? -divVal : divVal;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      opReg   <= '0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      neg     <= 1'b0;
      tagReg  <= '0;
      result  <= '0;
      tag_out <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          opReg  <= op;
          tagReg <= tag_in;
          neg    <= signNext;
          cnt    <= '0;
          hi     <= '0;
          lo     <= op[2] ? aMag : bMag;
          mcand  <= op[2] ? bMag : aMag;
          if (early) begin
            result  <= earlyRes;
            tag_out <= tag_in;
            state   <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          hi  <= stepHi;
          lo  <= stepLo;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            result  <= finalRes;
            tag_out <= tagReg;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    ready    = (state == IDLE);
    busy     = (state == CALC);
    done     = (state == DONE);
    dbgState = state;
  end

endmodule

// File: tb/tb_xgriscv_muldiv.sv
// Directed bench for xgriscv_muldiv: a 32-bit and an 8-bit instance, shared
// stimulus with per-instance start/kill gating selected by sel.
module tb_xgriscv_muldiv;

  logic        clk, rst32, rst8;
  logic        start, kill, sel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  tagIn;

  logic        ready32, busy32, done32;
  logic [31:0] result32;
  logic [4:0]  tag32;
  logic [1:0]  dbg32;
  logic        ready8, busy8, done8;
  logic [7:0]  result8;
  logic [4:0]  tag8;
  logic [1:0]  dbg8;

  logic        start32, start8, kill32, kill8;
  logic        obsBusy, obsDone, obsReady;
  logic [31:0] obsRes;
  logic [4:0]  obsTag;

  int nChecks = 0;
  int nErrors = 0;

  assign start32  = start & ~sel;
  assign start8   = start & sel;
  assign kill32   = kill & ~sel;
  assign kill8    = kill & sel;
  assign obsBusy  = sel ? busy8 : busy32;
  assign obsDone  = sel ? done8 : done32;
  assign obsReady = sel ? ready8 : ready32;
  assign obsRes   = sel ? {24'b0, result8} : result32;
  assign obsTag   = sel ? tag8 : tag32;

  xgriscv_muldiv #(.XLEN(32), .TAGW(5)) u32 (
    .clk(clk), .reset(rst32), .start(start32), .kill(kill32), .op(op),
    .a(a), .b(b), .tag_in(tagIn), .ready(ready32), .busy(busy32),
    .done(done32), .result(result32), .tag_out(tag32), .dbgState(dbg32)
  );

  xgriscv_muldiv #(.XLEN(8), .TAGW(5)) u8i (
    .clk(clk), .reset(rst8), .start(start8), .kill(kill8), .op(op),
    .a(a[7:0]), .b(b[7:0]), .tag_in(tagIn), .ready(ready8), .busy(busy8),
    .done(done8), .result(result8), .tag_out(tag8), .dbgState(dbg8)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", nm, obs, exp);
    end
  endtask

  // Issue one operation and watch 45 cycles. killAt=0 raises kill together
  // with start; killAt/pokeAt=s raise kill/start for the edge after sample s.
  // doneAt is the sample index (1 = cycle right after accept) of the first done.
  task automatic run(input string nm, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [4:0] t, input int killAt,
                     input int pokeAt, input logic [31:0] expRes, input logic [4:0] expTag,
                     input int expDoneAt, input int expBusy);
    int doneAt, busyCnt, doneCnt;
    doneAt = 0; busyCnt = 0; doneCnt = 0;
    @(negedge clk);
    op = o; a = x; b = y; tagIn = t; start = 1'b1; kill = (killAt == 0);
    for (int s = 1; s <= 45; s++) begin
      @(negedge clk);
      if (obsBusy) busyCnt++;
      if (obsDone) begin
        doneCnt++;
        if (doneAt == 0) doneAt = s;
      end
      start = (s == pokeAt);
      kill  = (s == killAt);
      op    = 3'($urandom_range(0, 7));
      a     = $urandom;
      b     = $urandom;
      tagIn = 5'($urandom_range(0, 31));
    end
    start = 1'b0;
    kill  = 1'b0;
    check({nm, " doneAt"}, doneAt, expDoneAt);
    check({nm, " doneCnt"}, doneCnt, (expDoneAt != 0) ? 1 : 0);
    check({nm, " busyCycles"}, busyCnt, expBusy);
    check({nm, " result"}, obsRes, expRes);
    check({nm, " tag"}, {27'b0, obsTag}, {27'b0, expTag});
    check({nm, " readyAfter"}, {31'b0, obsReady}, 32'd1);
  endtask

  initial begin
    rst32 = 1'b0; rst8 = 1'b0; start = 1'b0; kill = 1'b0; sel = 1'b0;
    op = '0; a = '0; b = '0; tagIn = '0;
    #12;
    check("rst ready", {31'b0, ready32}, 32'd1);
    check("rst busy", {31'b0, busy32}, 32'd0);
    check("rst done", {31'b0, done32}, 32'd0);
    check("rst result", result32, 32'd0);
    check("rst tag", {27'b0, tag32}, 32'd0);
    @(negedge clk);
    rst32 = 1'b1; rst8 = 1'b1;

    // 32-bit: normal operations finish XLEN cycles after accept
    run("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd1, -1, -1, 32'hFFFFFFEB, 5'd1, 33, 32);
    run("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd2, -1, -1, 32'h40000000, 5'd2, 33, 32);
    run("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, -1, -1, 32'hFFFFFFFE, 5'd3, 33, 32);
    run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        5'd4, -1, -1, 32'hFFFFFFFF, 5'd4, 33, 32);
    run("divu",   3'd5, 32'd100,      32'd7,        5'd5, -1, -1, 32'd14,       5'd5, 33, 32);
    run("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd6, -1, -1, 32'hFFFFFFFF, 5'd6, 33, 32);
    run("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd7, -1, -1, 32'hFFFFFFFD, 5'd7, 33, 32);
    run("remu",   3'd7, 32'hFFFFFFFF, 32'd16,       5'd8, -1, -1, 32'h0000000F, 5'd8, 33, 32);

    // 32-bit early-outs: done in the cycle right after accept, never busy
    run("divz",   3'd4, 32'h00001234, 32'd0,        5'd9,  -1, -1, 32'hFFFFFFFF, 5'd9,  1, 0);
    run("remuz",  3'd7, 32'd5,        32'd0,        5'd10, -1, -1, 32'd5,        5'd10, 1, 0);
    run("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, -1, -1, 32'h80000000, 5'd11, 1, 0);
    run("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, -1, -1, 32'd0,        5'd12, 1, 0);

    // Kill in CALC keeps previous result/tag; kill+start in IDLE accepts nothing
    run("kill",      3'd0, 32'd3,   32'd5, 5'd13, 11, -1, 32'd0,  5'd12, 0, 11);
    run("startkill", 3'd0, 32'd9,   32'd9, 5'd14, 0,  -1, 32'd0,  5'd12, 0, 0);
    // start during CALC is ignored (inputs also scrambled after accept)
    run("poke",      3'd5, 32'd100, 32'd7, 5'd15, -1, 5,  32'd14, 5'd15, 33, 32);

    // 8-bit instance
    sel = 1'b1;
    run("mulhu8", 3'd3, 32'hFF, 32'hFF, 5'd1, -1, -1, 32'hFE, 5'd1, 9, 8);
    run("div8",   3'd4, 32'hF9, 32'h02, 5'd2, -1, -1, 32'hFD, 5'd2, 9, 8);

    // Reset mid-CALC on the 8-bit instance takes effect without a clock edge
    @(negedge clk);
    op = 3'd3; a = 32'hFF; b = 32'hFF; tagIn = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid busy8", {31'b0, busy8}, 32'd1);
    #2 rst8 = 1'b0;
    #1;
    check("rst8 ready", {31'b0, ready8}, 32'd1);
    check("rst8 busy", {31'b0, busy8}, 32'd0);
    check("rst8 done", {31'b0, done8}, 32'd0);
    check("rst8 result", {24'b0, result8}, 32'd0);
    check("rst8 tag", {27'b0, tag8}, 32'd0);
    @(negedge clk);
    rst8 = 1'b1;
    repeat (12) @(negedge clk);
    check("rst8 noDone", {31'b0, done8}, 32'd0);
    check("rst8 idle", {31'b0, ready8}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/xgriscv_muldiv.md
# xgriscv_muldiv

Iterative, parametrised RV32M/RV64M multiply/divide unit that sits beside the ALU in the execute stage of the xgriscv pipeline. It accepts one operation at a time and produces a result after a fixed number of cycles, holding the pipeline with `busy` in the meantime. Divide-by-zero and signed overflow resolve early. A flush from the branch/jump logic (`kill`) aborts an operation in flight.

## Interface
- `XLEN`, 32: operand and result width; must be even and ≥ 8.
- `TAGW`, 5: width of the destination-register tag carried with the operation.
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset).
- `start`  in  1: request a new operation; sampled only while idle.
- `kill`  in  1: abort; flush from the pipeline's pcsrc.
- `op`  in  3: funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a`  in  XLEN: rs1 operand.
- `b`  in  XLEN: rs2 operand.
- `tag_in`  in  TAGW: rd index of the requesting instruction.
- `ready`  out  1: unit idle; `start` will be accepted this cycle.
- `busy`  out  1: operation in progress; the pipeline stalls the execute stage and the stages before it.
- `done`  out  1: single-cycle pulse; `result` and `tag_out` are valid.
- `result`  out  XLEN: operation result; holds its value until the next accept.
- `tag_out`  out  TAGW: the `tag_in` latched at accept.

## Operation
- **States**
  - IDLE: `ready`=1.
  - CALC: `busy`=1.
  - DONE: `done`=1.
- **Accept**
  - Condition: IDLE with `start`=1 and `kill`=0 at a rising edge.
  - At that edge the unit latches `op`, `a`, `b` and `tag_in`, and clears the iteration counter.
  - Early-out cases go directly to DONE. All other cases go to CALC.
- **Operand preparation**
  - Signed operands are converted to magnitudes at accept.
    - MULH: both operands.
    - MULHSU: `a` only.
    - DIV and REM: both operands.
  - Result sign is recorded at accept.
    - Product: XOR of the operand signs.
    - Quotient: XOR of the operand signs.
    - Remainder: sign of the dividend.
- **Multiply**
  - Shift-add, one multiplier bit per cycle, XLEN iterations into a 2·XLEN accumulator.
  - The accumulator is negated at the end if the product sign is negative.
  - MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits.
- **Divide**
  - Restoring division, one quotient bit per cycle, XLEN iterations.
  - The quotient and remainder are negated according to their recorded signs.
- **Early-outs** (taken at accept, no CALC)
  - Divisor = 0:
    - DIV/DIVU return all-ones.
    - REM/REMU return `a`.
  - DIV/REM with `a` = 100…0 and `b` = all-ones:
    - DIV returns `a`.
    - REM returns 0.
- **CALC → DONE**: on the edge that completes iteration XLEN.
- **DONE → IDLE**: unconditionally on the next edge.
- **`start` outside IDLE**: ignored; nothing is queued.
- **`kill`** (any state, at a rising edge)
  - The state goes to IDLE and any pending `done` is suppressed.
  - `result` and `tag_out` are not updated by a killed operation.
  - If `kill` and `start` are both high in IDLE, `kill` wins and nothing is accepted.
- **Reset**
  - State IDLE; `ready`=1, `busy`=0, `done`=0.
  - `result`=0, `tag_out`=0, counter=0.
  - Reset during CALC or DONE discards the operation.

## Timing
- Let E0 be the accept edge.
- **Normal case**
  - `busy` is high from E0 through the edge E_XLEN.
  - `done` is high for exactly the one cycle after E_XLEN, and is low again after E_XLEN+1.
  - At E_XLEN+1 the unit returns to IDLE.
- **Early-out**
  - `done` is high for the one cycle after E0, and the unit is IDLE after E0+1.
- **Back-to-back operations**
  - `ready` asserts in the cycle after the `done` cycle.
  - Minimum issue interval: XLEN+2 cycles normal, 2 cycles early-out.
- **Outputs**
  - All outputs are registered or decoded directly from the state register; there is no combinational path from the inputs.
  - Exception: `ready` is a state decode only.

## Test plan
- **MUL (XLEN=32)**: `a`=7, `b`=0xFFFFFFFD.
  - Result 0xFFFFFFEB.
  - `done` exactly 32 cycles after accept; `busy` high for 32 cycles.
- **High products**
  - MULH with 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU with 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- **Division**
  - DIVU 100/7 → 14.
  - REM −7 rem 2 → 0xFFFFFFFF.
  - DIV −7/2 → 0xFFFFFFFD.
  - Each with `tag_out` equal to the `tag_in` given at accept.
- **Early-outs**
  - DIV x/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - Each with `done` one cycle after accept and `busy` never asserted.
- **Kill and ignored start**
  - `kill` at CALC cycle 10: `done` never pulses and `result` keeps its previous value.
  - `start` asserted during CALC is ignored.
  - `start` with `kill` in IDLE: no accept.
- **XLEN=8 instance**
  - MULHU 0xFF × 0xFF → 0xFE, `done` after 8 cycles.
  - Assert reset mid-CALC: all outputs return to their reset values immediately.
